// File: rtl/fp_mul_pipe.sv
// Three-stage IEEE-754 single-precision multiplier: unpack/exponent, mantissa product, normalize/round/pack.
// Denormal inputs are treated as zero and tiny results flush to signed zero; every NaN result is QNAN.
module fp_mul_pipe #(
  parameter int          LATENCY = 3,
  parameter logic [31:0] QNAN    = 32'h7FC00000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] c,
  output logic [3:0]  flags
);

  // Handshake: a pair is accepted when in_valid & in_ready, a result leaves when
  // out_valid & out_ready; the whole pipe advances together whenever the output slot is free or drained.
  logic w_en;
  assign w_en      = !out_valid || out_ready;
  assign in_ready  = w_en;

  logic [LATENCY-1:0] r_vld;
  assign out_valid = r_vld[LATENCY-1];

  // Stage 1 combinational: classification and special-case result
  logic [7:0]  w_ea, w_eb;
  logic [22:0] w_fa, w_fb;
  logic        w_za, w_zb, w_ia, w_ib, w_na, w_nb, w_sa, w_sb, w_s;
  logic        w_spec;
  logic [31:0] w_spec_c;
  logic [3:0]  w_spec_f;

  assign w_ea = a[30:23];
  assign w_eb = b[30:23];
  assign w_fa = a[22:0];
  assign w_fb = b[22:0];
  assign w_s  = a[31] ^ b[31];
  assign w_za = (w_ea == 8'd0);
  assign w_zb = (w_eb == 8'd0);
  assign w_ia = (w_ea == 8'hFF) && (w_fa == 23'd0);
  assign w_ib = (w_eb == 8'hFF) && (w_fb == 23'd0);
  assign w_na = (w_ea == 8'hFF) && (w_fa != 23'd0);
  assign w_nb = (w_eb == 8'hFF) && (w_fb != 23'd0);
  assign w_sa = w_na && !w_fa[22];
  assign w_sb = w_nb && !w_fb[22];

  always_comb begin
    w_spec   = 1'b1;
    w_spec_c = QNAN;
    w_spec_f = 4'b0000;
    if (w_na || w_nb) begin
      w_spec_f = {(w_sa || w_sb), 3'b000};
    end else if ((w_ia && w_zb) || (w_za && w_ib)) begin
      w_spec_f = 4'b1000;
    end else if (w_ia || w_ib) begin
      w_spec_c = {w_s, 8'hFF, 23'h0};
    end else if (w_za || w_zb) begin
      w_spec_c = {w_s, 31'h0};
    end else begin
      w_spec = 1'b0;
    end
  end

  // Stage 1 registers
  logic               r_s1, r_spec1;
  logic signed [9:0]  r_e1;
  logic [23:0]        r_ma1, r_mb1;
  logic [31:0]        r_spec_c1;
  logic [3:0]         r_spec_f1;

  // Stage 2 registers
  logic               r_s2, r_spec2;
  logic signed [9:0]  r_e2;
  logic [47:0]        r_p2;
  logic [31:0]        r_spec_c2;
  logic [3:0]         r_spec_f2;

  always_ff @(posedge clk) begin
    if (w_en) begin
      r_s1      <= w_s;
      r_e1      <= $signed({2'b00, w_ea} + {2'b00, w_eb} - 10'd127);
      r_ma1     <= {1'b1, w_fa};
      r_mb1     <= {1'b1, w_fb};
      r_spec1   <= w_spec;
      r_spec_c1 <= w_spec_c;
      r_spec_f1 <= w_spec_f;

      r_s2      <= r_s1;
      r_e2      <= r_e1;
      r_p2      <= 48'(r_ma1) * 48'(r_mb1);
      r_spec2   <= r_spec1;
      r_spec_c2 <= r_spec_c1;
      r_spec_f2 <= r_spec_f1;
    end
  end

  // Stage 3 combinational: normalize, round to nearest even, select result
  logic               w_hi, w_g, w_st, w_rnd;
  logic [22:0]        w_m;
  logic [23:0]        w_mr;
  logic signed [9:0]  w_e_n, w_e_f;
  logic [31:0]        w_c;
  logic [3:0]         w_f;

  assign w_hi  = r_p2[47];
  assign w_m   = w_hi ? r_p2[46:24] : r_p2[45:23];
  assign w_g   = w_hi ? r_p2[23] : r_p2[22];
  assign w_st  = w_hi ? (|r_p2[22:0]) : (|r_p2[21:0]);
  assign w_rnd = w_g && (w_st || w_m[0]);
  assign w_mr  = {1'b0, w_m} + {23'd0, w_rnd};
  assign w_e_n = r_e2 + $signed({9'd0, w_hi});
  assign w_e_f = w_e_n + $signed({9'd0, w_mr[23]});

  always_comb begin
    w_c = {r_s2, w_e_f[7:0], w_mr[22:0]};
    w_f = {3'b000, (w_g || w_st)};
    if (r_spec2) begin
      w_c = r_spec_c2;
      w_f = r_spec_f2;
    end else if (w_e_f >= 10'sd255) begin
      w_c = {r_s2, 8'hFF, 23'h0};
      w_f = 4'b0101;
    end else if (w_e_f <= 10'sd0) begin
      w_c = {r_s2, 31'h0};
      w_f = 4'b0011;
    end
  end

  // Output stage keeps its last value across bubbles so c only changes when a result lands.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_vld <= '0;
      c     <= 32'd0;
      flags <= 4'd0;
    end else if (w_en) begin
      r_vld <= {r_vld[LATENCY-2:0], in_valid};
      if (r_vld[1]) begin
        c     <= w_c;
        flags <= w_f;
      end
    end
  end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Directed bench for fp_mul_pipe: literal vectors with latency checks, back-pressure
// ordering, and mid-flight reset, all cross-checked against an integer-arithmetic model.
module tb_fp_mul_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] tb_a = 32'd0;
  logic [31:0] tb_b = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] c;
  logic [3:0]  flags;

  fp_mul_pipe dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .a(tb_a), .b(tb_b),
    .out_valid(out_valid), .out_ready(out_ready), .c(c), .flags(flags)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int n_xfer = 0;
  logic [35:0] exp_q[$];
  logic [31:0] obs_q[$];

  localparam logic [31:0] QNAN = 32'h7FC00000;

  task automatic chk(input string nm, input logic [35:0] act, input logic [35:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: exact integer product, rounded by comparing the discarded remainder to one half.
  function automatic logic [35:0] model(input logic [31:0] x, input logic [31:0] y);
    logic [7:0]  ea, eb;
    logic [22:0] fa, fb;
    logic        s, za, zb, ia, ib, na, nb, sna, snb;
    logic [47:0] p, q, rem, half;
    int          sh, ex;
    ea = x[30:23]; eb = y[30:23]; fa = x[22:0]; fb = y[22:0];
    s  = x[31] ^ y[31];
    za = (ea == 0); zb = (eb == 0);
    ia = (ea == 255) && (fa == 0); ib = (eb == 255) && (fb == 0);
    na = (ea == 255) && (fa != 0); nb = (eb == 255) && (fb != 0);
    sna = na && (fa < 23'h400000); snb = nb && (fb < 23'h400000);
    if (na || nb) return {(sna || snb), 3'b000, QNAN};
    if ((ia && zb) || (za && ib)) return {4'b1000, QNAN};
    if (ia || ib) return {4'b0000, s, 8'hFF, 23'h0};
    if (za || zb) return {4'b0000, s, 31'h0};
    p    = (48'h800000 + 48'(fa)) * (48'h800000 + 48'(fb));
    sh   = (p >= 48'h800000000000) ? 24 : 23;
    ex   = int'(ea) + int'(eb) - 127 + sh - 23;
    q    = p >> sh;
    rem  = p - (q << sh);
    half = 48'd1 << (sh - 1);
    if (rem > half || (rem == half && q[0])) q = q + 1;
    if (q == 48'h1000000) begin
      q  = q >> 1;
      ex = ex + 1;
    end
    if (ex >= 255) return {4'b0101, s, 8'hFF, 23'h0};
    if (ex <= 0) return {4'b0011, s, 31'h0};
    return {3'b000, (rem != 0), s, 8'(ex), q[22:0]};
  endfunction

  // Compare process: model results queued at accept, checked at every transfer; stall stability too.
  logic        prev_stall = 1'b0;
  logic [36:0] prev_out = '0;
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      n_xfer++;
      obs_q.push_back(c);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_output: got %h expected none", {flags, c});
      end else begin
        chk("stream", {flags, c}, exp_q.pop_front());
      end
    end
    if (prev_stall) chk("stall_hold", {1'b0, prev_out[35:0]}, {1'b0, flags, c});
    if (prev_stall) chk("stall_valid", 36'(out_valid), 36'(prev_out[36]));
    if (rst && out_valid && !out_ready) chk("stall_in_ready", 36'(in_ready), 36'd0);
    if (!rst) exp_q.delete();
    else if (in_valid && in_ready) exp_q.push_back(model(tb_a, tb_b));
    prev_stall = rst && out_valid && !out_ready;
    prev_out   = {out_valid, flags, c};
  end

  task automatic drive_op(input logic [31:0] x, input logic [31:0] y);
    logic ok;
    tb_a = x;
    tb_b = y;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: got no accept expected accept for %h*%h", x, y);
    end
  endtask

  task automatic send_wait(input string nm, input logic [31:0] x, input logic [31:0] y,
                           input logic [35:0] exp);
    int lat;
    logic got;
    drive_op(x, y);
    in_valid = 1'b0;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 10) begin
      @(negedge clk);
      lat++;
      got = out_valid;
    end
    chk({nm, "_lat"}, 36'(lat), 36'd3);
    chk(nm, {flags, c}, exp);
    @(posedge clk);
    #1;
  endtask

  localparam int NV = 15;
  localparam logic [31:0] TV_A [NV] = '{
    32'h40000000, 32'h3F800001, 32'h3FC00000, 32'h7F7FFFFF, 32'h00800000,
    32'h7F800000, 32'h80000000, 32'h7F800001, 32'h3FFFFFFF, 32'h3F800001,
    32'h7FC00000, 32'hFF800000, 32'h00000000, 32'h00400000, 32'h3F800000};
  localparam logic [31:0] TV_B [NV] = '{
    32'h40400000, 32'h3F800001, 32'h3FC00000, 32'h40000000, 32'h00800000,
    32'h00000000, 32'h3F800000, 32'h3F800000, 32'h3FFFFFFF, 32'h3FFFFFFF,
    32'h40000000, 32'h40000000, 32'hFF800000, 32'h3F800000, 32'h7F800001};
  localparam logic [35:0] TV_E [NV] = '{
    {4'h0, 32'h40C00000}, {4'h1, 32'h3F800002}, {4'h0, 32'h40100000},
    {4'h5, 32'h7F800000}, {4'h3, 32'h00000000}, {4'h8, 32'h7FC00000},
    {4'h0, 32'h80000000}, {4'h8, 32'h7FC00000}, {4'h1, 32'h407FFFFE},
    {4'h1, 32'h40000000}, {4'h0, 32'h7FC00000}, {4'h0, 32'hFF800000},
    {4'h8, 32'h7FC00000}, {4'h0, 32'h00000000}, {4'h8, 32'h7FC00000}};
  localparam logic [31:0] BP_B [5] = '{
    32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000};

  initial begin
    // Reset
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 36'(out_valid), 36'd0);
    chk("rst_c_flags", {flags, c}, 36'd0);
    chk("rst_in_ready", 36'(in_ready), 36'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Directed vectors, one at a time
    for (int i = 0; i < NV; i++) send_wait($sformatf("vec%0d", i), TV_A[i], TV_B[i], TV_E[i]);

    // Back-pressure: five ops, output stalled for four cycles after the first result
    n_xfer = 0;
    obs_q.delete();
    fork
      begin
        for (int k = 0; k < 5; k++) drive_op(32'h3F800000, BP_B[k]);
        in_valid = 1'b0;
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          chk("bp_hold_valid", 36'(out_valid), 36'd1);
          chk("bp_hold_in_ready", 36'(in_ready), 36'd0);
          chk("bp_hold_c", {flags, c}, {4'h0, 32'h3F800000});
          @(posedge clk);
        end
        #1;
        out_ready = 1'b1;
      end
    join
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
    @(posedge clk);
    #1;
    chk("bp_count", 36'(n_xfer), 36'd5);
    for (int k = 0; k < 5; k++) begin
      if (k < obs_q.size()) chk($sformatf("bp_order%0d", k), 36'(obs_q[k]), 36'(BP_B[k]));
      else chk($sformatf("bp_order%0d", k), 36'hFFFFFFFFF, 36'(BP_B[k]));
    end

    // Reset with two ops in flight; an op offered during reset is dropped
    n_xfer = 0;
    drive_op(32'h40000000, 32'h40000000);
    drive_op(32'h40400000, 32'h40400000);
    tb_a = 32'h40800000;
    tb_b = 32'h40800000;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", 36'(out_valid), 36'd0);
    chk("midrst_c_flags", {flags, c}, 36'd0);
    repeat (6) begin
      @(negedge clk);
      chk("midrst_quiet", 36'(out_valid), 36'd0);
    end
    chk("midrst_xfer", 36'(n_xfer), 36'd0);
    @(posedge clk);
    #1;
    send_wait("post_rst", 32'h40000000, 32'h40400000, {4'h0, 32'h40C00000});

    repeat (3) @(posedge clk);
    chk("final_queue_empty", 36'(exp_q.size()), 36'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
